// File: rtl/geo_cmd_player_pkg.sv
// geo_cmd_player_pkg: shared widths, address step and player state encoding
package geo_cmd_player_pkg;
  localparam int GEO_WORD_W = 16;
  localparam int GEO_ADDR_W = 32;
  localparam logic [GEO_ADDR_W-1:0] ADDR_STEP = 32'd2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;
endpackage

// File: rtl/geo_cmd_player_fifo.sv
// geo_cmd_player_fifo: show-ahead word buffer with occupancy count and synchronous clear
module geo_cmd_player_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [W-1:0]             din,
  input  logic                     rd,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_rd = rd && count != '0;
  assign do_wr = wr && (count != FULL || do_rd);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_wr && !clr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/geo_cmd_list_player.sv
// geo_cmd_list_player: replays a RAM command list into the geometry FIFO; GEO_CMD_PLAYER_CHECKSUM_EN adds a strobed-word checksum
module geo_cmd_list_player
  import geo_cmd_player_pkg::*;
#(
  parameter int BUF_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [GEO_ADDR_W-1:0] list_addr,
  input  logic [15:0]           list_len,
  output logic                  rd_req,
  output logic [GEO_ADDR_W-1:0] ram_addr,
  input  logic [GEO_WORD_W-1:0] rd_data_in,
  input  logic                  rd_data_rdy,
  input  logic                  ram_mux_busy,
  input  logic                  fifo_cmd_busy,
  output logic                  fifo_cmd_ready,
  output logic [GEO_WORD_W-1:0] fifo_cmd_out,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_sent,
  output logic [GEO_WORD_W-1:0] checksum
);
  localparam int CW = $clog2(BUF_DEPTH);
  state_t state, state_n;
  logic [15:0] len_q, issued;
  logic [CW:0] inflight, count;
  logic [GEO_WORD_W-1:0] head;
  logic active, go, accept, resp, pop, clr;
  assign active = state == RUN || state == DRAIN;
  assign go = state == IDLE && start && !abort;
  // reads in flight plus buffered words never exceed the buffer, so it cannot overflow
  assign rd_req = state == RUN && issued != len_q &&
                  ({1'b0, inflight} + {1'b0, count}) < (CW+2)'(BUF_DEPTH);
  assign accept = rd_req && !ram_mux_busy;
  assign resp = rd_data_rdy && state != IDLE && inflight != '0;
  assign pop = active && count != '0 && !fifo_cmd_busy && !abort;
  assign clr = reset || (state_n == FLUSH && state != FLUSH);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go && list_len != '0 ? RUN : IDLE;
      RUN:     state_n = abort ? FLUSH : issued == len_q ? DRAIN : RUN;
      DRAIN:   state_n = abort ? FLUSH : count == '0 && inflight == '0 ? IDLE : DRAIN;
      default: state_n = inflight == '0 ? IDLE : FLUSH;
    endcase
  end
  geo_cmd_player_fifo #(.DEPTH(BUF_DEPTH), .W(GEO_WORD_W)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .wr    (rd_data_rdy && active),
    .din   (rd_data_in),
    .rd    (pop),
    .dout  (head),
    .count (count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ram_addr <= '0;
      len_q <= '0;
      issued <= '0;
      inflight <= '0;
      fifo_cmd_ready <= 1'b0;
      fifo_cmd_out <= '0;
      done <= 1'b0;
      words_sent <= '0;
    end else begin
      state <= state_n;
      done <= (state != IDLE || go) && state_n == IDLE;
      if (go) begin
        ram_addr <= list_addr & ~GEO_ADDR_W'(1);
        len_q <= list_len;
        issued <= '0;
      end else if (accept) begin
        ram_addr <= ram_addr + ADDR_STEP;
        issued <= issued + 16'd1;
      end
      inflight <= inflight + (CW+1)'(accept) - (CW+1)'(resp);
      fifo_cmd_ready <= pop;
      if (pop) fifo_cmd_out <= head;
      words_sent <= go ? '0 : words_sent + 16'(pop);
    end
  end
`ifdef GEO_CMD_PLAYER_CHECKSUM_EN
  logic [GEO_WORD_W-1:0] sum;
  always_ff @(posedge clk)
    if (reset || go) sum <= '0;
    else if (pop) sum <= sum + head;
  assign checksum = sum;
`else
  assign checksum = '0;
`endif
endmodule
